// File: rtl/counter_priority_arbiter.sv
// Eight-channel up/down pulse collector that grants one pending request at a
// time to a shared counter-increment sequencer, with a BUSY timeout.

module counter_priority_arbiter_chan (
    input  logic clk,
    input  logic rst,
    input  logic p,
    input  logic m,
    input  logic take,
    input  logic merge,
    input  logic merge_s,
    input  logic missclr,
    output logic pend_v,
    output logic pend_s,
    output logic miss
);
    logic v0, v1, s1, v2, s2, hit_pulse, hit_merge;

    always_comb begin
        // A granted request leaves the channel on the same edge, so a pulse
        // arriving alongside the grant sees an empty channel.
        v0 = take ? 1'b0 : pend_v;
        v1 = v0;
        s1 = pend_s;
        hit_pulse = 1'b0;
        if (p ^ m) begin
            if (!v0) begin
                v1 = 1'b1;
                s1 = m;
            end else if (pend_s != m) begin
                v1 = 1'b0;
            end else begin
                hit_pulse = 1'b1;
            end
        end
        v2 = v1;
        s2 = s1;
        hit_merge = 1'b0;
        if (merge) begin
            if (!v1) begin
                v2 = 1'b1;
                s2 = merge_s;
            end else if (s1 != merge_s) begin
                v2 = 1'b0;
            end else begin
                hit_merge = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v <= 1'b0;
            pend_s <= 1'b0;
            miss   <= 1'b0;
        end else begin
            pend_v <= v2;
            pend_s <= s2;
            miss   <= (miss & ~missclr) | hit_pulse | hit_merge;
        end
    end
endmodule

module counter_priority_arbiter #(
    parameter int TMO = 15
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       PIPXP,
    input  logic       PIPXM,
    input  logic       PIPYP,
    input  logic       PIPYM,
    input  logic       PIPZP,
    input  logic       PIPZM,
    input  logic       CDUXP,
    input  logic       CDUXM,
    input  logic       CDUYP,
    input  logic       CDUYM,
    input  logic       CDUZP,
    input  logic       CDUZM,
    input  logic       TRNP,
    input  logic       TRNM,
    input  logic       SHAFTP,
    input  logic       SHAFTM,
    input  logic       SLOT,
    input  logic       CDONE,
    input  logic [7:0] MISSCLR,
    output logic       CTROR,
    output logic       PINC,
    output logic       MINC,
    output logic [2:0] CADR,
    output logic [7:0] MISS,
    output logic       TMOERR
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [7:0] p_pulse, m_pulse, pend_v, pend_s, take, merge;
    logic [0:0] state;
    logic       grant_s;
    logic [2:0] gadr, sel;
    logic [7:0] cnt;
    logic       grant_fire, tmo_hit;

    assign p_pulse = {SHAFTP, TRNP, CDUZP, CDUYP, CDUXP, PIPZP, PIPYP, PIPXP};
    assign m_pulse = {SHAFTM, TRNM, CDUZM, CDUYM, CDUXM, PIPZM, PIPYM, PIPXM};

    always_comb begin
        sel = '0;
        for (int i = 7; i >= 0; i--)
            if (pend_v[i]) sel = 3'(i);
    end

    assign grant_fire = (state == IDLE) && SLOT && (|pend_v);
    // CDONE on the last allowed cycle is a normal completion, not a timeout.
    assign tmo_hit    = (state == BUSY) && !CDONE && (cnt == 8'(TMO - 1));

    generate
        for (genvar g = 0; g < 8; g++) begin : g_ch
            assign take[g]  = grant_fire && (sel == 3'(g));
            assign merge[g] = tmo_hit && (gadr == 3'(g));
            counter_priority_arbiter_chan u_chan (
                .clk     (CLOCK),
                .rst     (rst),
                .p       (p_pulse[g]),
                .m       (m_pulse[g]),
                .take    (take[g]),
                .merge   (merge[g]),
                .merge_s (grant_s),
                .missclr (MISSCLR[g]),
                .pend_v  (pend_v[g]),
                .pend_s  (pend_s[g]),
                .miss    (MISS[g])
            );
        end
    endgenerate

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state   <= IDLE;
            grant_s <= 1'b0;
            gadr    <= '0;
            cnt     <= '0;
            CTROR   <= 1'b0;
            TMOERR  <= 1'b0;
        end else begin
            CTROR  <= |pend_v;
            TMOERR <= tmo_hit;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        state   <= BUSY;
                        grant_s <= pend_s[sel];
                        gadr    <= sel;
                        cnt     <= '0;
                    end
                end
                default: begin
                    if (CDONE || tmo_hit) state <= IDLE;
                    else                  cnt   <= cnt + 8'd1;
                end
            endcase
        end
    end

    assign PINC = (state == BUSY) && !grant_s;
    assign MINC = (state == BUSY) &&  grant_s;
    assign CADR = gadr;
endmodule

// File: tb/tb_counter_priority_arbiter.sv
// Directed bench: stimulus pushes expected grant/timeout events into a
// scoreboard that a negedge monitor pops as the DUT presents them.

module tb_counter_priority_arbiter;
    logic       CLOCK = 1'b0;
    logic       rst = 1'b1;
    logic       PIPXP = 0, PIPXM = 0, PIPYP = 0, PIPYM = 0, PIPZP = 0, PIPZM = 0;
    logic       CDUXP = 0, CDUXM = 0, CDUYP = 0, CDUYM = 0, CDUZP = 0, CDUZM = 0;
    logic       TRNP = 0, TRNM = 0, SHAFTP = 0, SHAFTM = 0;
    logic       SLOT = 0, CDONE = 0;
    logic [7:0] MISSCLR = '0;
    logic       CTROR, PINC, MINC, TMOERR;
    logic [2:0] CADR;
    logic [7:0] MISS;

    typedef struct {
        bit       tmo;
        bit       pinc;
        bit       minc;
        bit [2:0] cadr;
    } ev_t;

    ev_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    bit  prev_act = 1'b0;

    counter_priority_arbiter #(.TMO(15)) dut (
        .CLOCK(CLOCK), .rst(rst),
        .PIPXP(PIPXP), .PIPXM(PIPXM), .PIPYP(PIPYP), .PIPYM(PIPYM),
        .PIPZP(PIPZP), .PIPZM(PIPZM),
        .CDUXP(CDUXP), .CDUXM(CDUXM), .CDUYP(CDUYP), .CDUYM(CDUYM),
        .CDUZP(CDUZP), .CDUZM(CDUZM),
        .TRNP(TRNP), .TRNM(TRNM), .SHAFTP(SHAFTP), .SHAFTM(SHAFTM),
        .SLOT(SLOT), .CDONE(CDONE), .MISSCLR(MISSCLR),
        .CTROR(CTROR), .PINC(PINC), .MINC(MINC), .CADR(CADR),
        .MISS(MISS), .TMOERR(TMOERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLOCK);
    endtask

    task automatic exp_grant(input bit p, input bit m, input bit [2:0] a);
        ev_t e;
        e.tmo = 1'b0; e.pinc = p; e.minc = m; e.cadr = a;
        sb.push_back(e);
    endtask

    task automatic exp_tmo();
        ev_t e;
        e.tmo = 1'b1; e.pinc = 1'b0; e.minc = 1'b0; e.cadr = '0;
        sb.push_back(e);
    endtask

    // Monitor: a grant start is a rising PINC|MINC; a timeout is a TMOERR pulse.
    always @(negedge CLOCK) begin
        ev_t e;
        bit  act;
        act = PINC | MINC;
        if (act && !prev_act) begin
            if (sb.size() == 0) chk("sb_unexpected_grant", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_grant_kind", 0, int'(e.tmo));
                chk("sb_grant_pinc", int'(PINC), int'(e.pinc));
                chk("sb_grant_minc", int'(MINC), int'(e.minc));
                chk("sb_grant_cadr", int'(CADR), int'(e.cadr));
            end
        end
        if (TMOERR) begin
            if (sb.size() == 0) chk("sb_unexpected_tmoerr", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_tmo_kind", 1, int'(e.tmo));
                chk("sb_tmo_idle", int'(act), 0);
            end
        end
        prev_act = act;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step(); step();
        chk("rst_ctror", int'(CTROR), 0);
        chk("rst_pinc", int'(PINC), 0);
        chk("rst_minc", int'(MINC), 0);
        chk("rst_cadr", int'(CADR), 0);
        chk("rst_miss", int'(MISS), 0);
        chk("rst_tmoerr", int'(TMOERR), 0);
        rst = 1'b0;
        step();

        // SLOT with nothing pending is ignored
        SLOT = 1; step(); SLOT = 0;
        chk("empty_slot_pinc", int'(PINC | MINC), 0);

        // Single plus request on channel 1
        PIPYP = 1; step(); PIPYP = 0;
        chk("y_ctror_lag", int'(CTROR), 0);
        step();
        chk("y_ctror", int'(CTROR), 1);
        step();
        exp_grant(1, 0, 3'd1);
        SLOT = 1; step(); SLOT = 0;
        chk("y_pinc", int'(PINC), 1);
        chk("y_cadr", int'(CADR), 1);
        CDONE = 1; step(); CDONE = 0;
        chk("y_done_pinc", int'(PINC), 0);
        chk("y_done_ctror", int'(CTROR), 0);

        // Priority: channel 0 beats channel 5; SLOT during BUSY ignored
        CDUZM = 1; PIPXP = 1; step(); CDUZM = 0; PIPXP = 0;
        exp_grant(1, 0, 3'd0);
        SLOT = 1; step(); SLOT = 0;
        chk("pri_minc", int'(MINC), 0);
        chk("pri_pinc", int'(PINC), 1);
        chk("pri_cadr", int'(CADR), 0);
        SLOT = 1; step(); SLOT = 0;
        chk("busy_slot_cadr", int'(CADR), 0);
        CDONE = 1; step(); CDONE = 0;
        exp_grant(0, 1, 3'd5);
        SLOT = 1; step(); SLOT = 0;
        chk("pri2_minc", int'(MINC), 1);
        chk("pri2_cadr", int'(CADR), 5);
        CDONE = 1; step(); CDONE = 0;
        step();

        // Net-zero cancel and MISS on channel 6
        TRNP = 1; step(); TRNP = 0;
        TRNM = 1; step(); TRNM = 0;
        TRNP = 1; step(); TRNP = 0;
        chk("trn_cancel_ctror", int'(CTROR), 0);
        chk("trn_miss0", int'(MISS), 0);
        step();
        chk("trn_ctror", int'(CTROR), 1);
        TRNP = 1; step(); TRNP = 0;
        chk("trn_miss_set", int'(MISS), 8'h40);
        TRNP = 1; MISSCLR = 8'h40; step(); TRNP = 0; MISSCLR = '0;
        chk("trn_missclr_collide", int'(MISS), 8'h40);
        MISSCLR = 8'h40; step(); MISSCLR = '0;
        chk("trn_missclr", int'(MISS), 0);
        exp_grant(1, 0, 3'd6);
        SLOT = 1; step(); SLOT = 0;
        CDONE = 1; step(); CDONE = 0;
        step();

        // Timeout on channel 7 minus, then requeued grant completes on cycle 15
        SHAFTM = 1; step(); SHAFTM = 0;
        exp_grant(0, 1, 3'd7);
        SLOT = 1; step(); SLOT = 0;
        exp_tmo();
        repeat (14) step();
        chk("tmo_still_busy", int'(MINC), 1);
        step();
        chk("tmo_pulse", int'(TMOERR), 1);
        chk("tmo_minc_drop", int'(MINC), 0);
        step();
        chk("tmo_pulse_end", int'(TMOERR), 0);
        chk("tmo_requeue_ctror", int'(CTROR), 1);
        exp_grant(0, 1, 3'd7);
        SLOT = 1; step(); SLOT = 0;
        chk("requeue_cadr", int'(CADR), 7);
        repeat (14) step();
        CDONE = 1; step(); CDONE = 0;
        chk("cdone_last_minc", int'(MINC), 0);
        chk("cdone_last_tmoerr", int'(TMOERR), 0);
        step();
        chk("cdone_last_tmoerr2", int'(TMOERR), 0);

        // Simultaneous P and M ignored
        PIPZP = 1; PIPZM = 1; step(); PIPZP = 0; PIPZM = 0;
        step();
        chk("pm_ctror", int'(CTROR), 0);
        chk("pm_miss", int'(MISS), 0);

        // Reset during BUSY discards the grant
        PIPXP = 1; step(); PIPXP = 0;
        exp_grant(1, 0, 3'd0);
        SLOT = 1; step(); SLOT = 0;
        chk("rb_pinc", int'(PINC), 1);
        rst = 1; step(); rst = 0;
        chk("rb_pinc0", int'(PINC), 0);
        chk("rb_minc0", int'(MINC), 0);
        chk("rb_cadr0", int'(CADR), 0);
        chk("rb_ctror0", int'(CTROR), 0);
        chk("rb_miss0", int'(MISS), 0);
        chk("rb_tmoerr0", int'(TMOERR), 0);
        step(); step();
        chk("rb_no_requeue", int'(CTROR), 0);
        chk("rb_no_tmoerr", int'(TMOERR), 0);
        step();

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_priority_arbiter.md
COUNTER_PRIORITY_ARBITER -- requirements
Module: counter_priority_arbiter

Interface
REQ-001 Parameter TMO, default 15: maximum number of BUSY cycles allowed before a grant is abandoned (range 1..255).
REQ-002 The block SHALL have one clock, CLOCK, and SHALL use a synchronous, active-high reset, rst.
REQ-003 CLOCK  in  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 PIPXP, PIPXM, PIPYP, PIPYM, PIPZP, PIPZM  in  1 each  plus/minus count pulses for channels 0-2; each pulse is 1 cycle and already synchronized.
REQ-006 CDUXP, CDUXM, CDUYP, CDUYM, CDUZP, CDUZM  in  1 each  plus/minus pulses for channels 3-5.
REQ-007 TRNP, TRNM, SHAFTP, SHAFTM  in  1 each  plus/minus pulses for channels 6-7.
REQ-008 SLOT  in  1  one-cycle strobe from the sequencer: a counter-increment slot is available.
REQ-009 CDONE  in  1  one-cycle strobe from the sequencer: the granted increment has been written.
REQ-010 MISSCLR  in  8  per-channel write-1-to-clear for MISS.
REQ-011 CTROR  out  1  high when any channel has a pending request.
REQ-012 PINC, MINC  out  1 each  increment/decrement command for the granted channel; never both high.
REQ-013 CADR  out  3  granted channel index; valid whenever PINC or MINC is high.
REQ-014 MISS  out  8  sticky per-channel lost-pulse flags.
REQ-015 TMOERR  out  1  one-cycle pulse when a grant is abandoned by timeout.

Function
REQ-016 Each channel SHALL hold a pending request: empty, plus or minus.
REQ-017 P and M asserted together on one channel SHALL be ignored.
REQ-018 A pulse on an empty channel SHALL set a pending request of that sign on the next edge.
REQ-019 A pulse opposite to the channel's pending sign SHALL clear the request (net zero) and SHALL NOT set MISS.
REQ-020 A pulse of the same sign as the pending request SHALL leave it unchanged and SHALL set that channel's MISS bit.
REQ-021 CTROR SHALL equal the OR of all pending requests, registered, so it follows a request change by one cycle.
REQ-022 The FSM SHALL have two states, IDLE and BUSY, and SHALL reset to IDLE.
REQ-023 In IDLE, on SLOT with at least one pending request, the block SHALL select the lowest-numbered pending channel (channel 0 highest priority).
REQ-024 On that selection, the block SHALL move the request into the grant register, clear the channel's pending request on the same edge, and enter BUSY.
REQ-025 PINC/MINC and CADR SHALL assert on the cycle after SLOT and SHALL hold steady throughout BUSY.
REQ-026 SLOT in IDLE with no pending request SHALL be ignored.
REQ-027 SLOT during BUSY SHALL be ignored.
REQ-028 CDONE in BUSY SHALL return the FSM to IDLE, dropping PINC/MINC on the next cycle.
REQ-029 CDONE in IDLE SHALL be ignored.
REQ-030 Pulses on the granted channel during BUSY SHALL be handled as if the channel were empty (REQ-018..020); the grant is not affected.
REQ-031 A BUSY cycle counter SHALL clear on BUSY entry.
REQ-032 If TMO cycles elapse in BUSY without CDONE, the FSM SHALL return to IDLE and pulse TMOERR for one cycle.
REQ-033 On timeout, the grant SHALL be merged back into its channel: empty becomes the grant sign; same sign keeps one request and sets MISS; opposite sign clears both.
REQ-034 CDONE arriving on the timeout cycle SHALL take precedence: normal completion, no TMOERR.
REQ-035 Requests SHALL latch while SLOT fires; a request arriving on the SLOT edge SHALL become eligible only at the next SLOT.
REQ-036 A MISSCLR bit SHALL clear its MISS bit unless a new miss occurs on the same cycle, in which case MISS stays 1.

Reset
REQ-037 rst SHALL clear all pending requests, the grant and the timeout counter, and SHALL force IDLE.
REQ-038 Reset values: CTROR=0, PINC=0, MINC=0, CADR=0, MISS=0, TMOERR=0.
REQ-039 rst during BUSY SHALL discard the grant without re-queueing it and without TMOERR.

Verification
REQ-040 PIPYP pulse; SLOT 3 cycles later -> CTROR=1 after 1 cycle; next cycle after SLOT: PINC=1, CADR=1; CDONE -> PINC=0, CTROR=0.
REQ-041 CDUZM and PIPXP pending; SLOT -> MINC=0, PINC=1, CADR=0; after CDONE and a 2nd SLOT -> MINC=1, CADR=5.
REQ-042 TRNP, then TRNM, then TRNP again, with no SLOT -> pending only after the 3rd pulse, MISS=0; a 4th TRNP -> MISS[6]=1; MISSCLR[6] -> MISS[6]=0.
REQ-043 SHAFTM granted, no CDONE for TMO=15 cycles -> TMOERR pulse, IDLE, channel 7 minus pending, CTROR=1; CDONE on the 15th cycle instead -> no TMOERR.
REQ-044 PIPZP and PIPZM in the same cycle -> no request, MISS=0; rst asserted in BUSY -> all outputs 0 on the next cycle, no TMOERR.
